accumulator_16b: RTL and testbench

- Sequential stage that feeds the 16-bit carry-lookahead adder and consumes its result.
- Accepts a stream of 16-bit operands over a valid/ready handshake and sums them into a running register, operand_n + acc.
- Emits the final sum, a sticky carry-out flag and a term count when the packet ends.
- Sits between an operand source (e.g. a datapath FIFO) and any result consumer in the math subsystem.

---
 rtl/math_pkg.sv | 44 ++++
 rtl/accumulator_16b_ctrl.sv | 77 +++++++
 rtl/accumulator_16b.sv | 75 +++++++
 tb/tb_accumulator_16b.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared types and arithmetic helpers for the math subsystem: accumulator FSM
// state encoding and a 16-bit block carry-lookahead adder.
package math_pkg;

    localparam int ACC_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_ACCUM,
        ACC_DONE
    } acc_state_t;

    // Four 4-bit groups: group generate/propagate feed a lookahead carry
    // network, carries ripple only inside each group. Returns {carry_out, sum}.
    function automatic logic [16:0] cla_add16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [16:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        c     = '0;
        c[4]  = gg[0];
        c[8]  = gg[1] | (gp[1] & gg[0]);
        c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);
        c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
        for (int k = 0; k < 4; k++) begin
            for (int i = 1; i < 4; i++) begin
                c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
            end
        end
        return {c[16], p ^ c[15:0]};
    endfunction

endpackage

// File: rtl/accumulator_16b_ctrl.sv
// Packet control for the accumulator: IDLE/ACCUM/DONE state machine,
// input/output handshake decode and the per-packet term counter.
module accumulator_16b_ctrl
    import math_pkg::*;
#(
    parameter int MAX_TERMS = 16,
    parameter int CNT_WIDTH = $clog2(MAX_TERMS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    input  logic                 ready_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic                 in_fire,
    output logic                 out_fire,
    output logic                 start,
    output logic [CNT_WIDTH-1:0] count_o
);

    acc_state_t           state_q;
    acc_state_t           state_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_inc;

    assign count_inc = count_q + 1'b1;
    assign in_fire   = valid_i & ready_o;
    assign out_fire  = valid_o & ready_i;
    assign count_o   = count_q;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        start   = 1'b0;
        case (state_q)
            ACC_IDLE: begin
                ready_o = 1'b1;
                start   = 1'b1;
                if (valid_i) begin
                    state_d = (last_i || MAX_TERMS == 1) ? ACC_DONE : ACC_ACCUM;
                end
            end
            ACC_ACCUM: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_d = (last_i || count_inc == CNT_WIDTH'(MAX_TERMS)) ? ACC_DONE : ACC_ACCUM;
                end
            end
            ACC_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = ACC_IDLE;
                end
            end
            default: state_d = ACC_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ACC_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (out_fire) begin
                count_q <= '0;
            end else if (in_fire) begin
                count_q <= start ? CNT_WIDTH'(1) : count_inc;
            end
        end
    end

endmodule

// File: rtl/accumulator_16b.sv
// Streaming 16-bit accumulator: sums a packet of operands through the CLA adder.
// Define ACCUMULATOR_16B_SATURATE_EN to clamp the sum at 16'hFFFF on overflow.
module accumulator_16b
    import math_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_TERMS  = 16,
    parameter int CNT_WIDTH  = $clog2(MAX_TERMS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  carry_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    logic                      in_fire;
    logic                      out_fire;
    logic                      start;
    logic [DATA_WIDTH-1:0]     acc_q;
    logic                      carry_q;
    logic [ACC_DATA_WIDTH:0]   add_res;

    accumulator_16b_ctrl #(
        .MAX_TERMS (MAX_TERMS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .last_i   (last_i),
        .ready_i  (ready_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .in_fire  (in_fire),
        .out_fire (out_fire),
        .start    (start),
        .count_o  (count_o)
    );

    assign add_res = cla_add16(acc_q, operand_i);

    // Reset has priority; in_fire and out_fire are never high together (DONE blocks input).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (out_fire) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (in_fire) begin
            if (start) begin
                acc_q   <= operand_i;
                carry_q <= 1'b0;
            end else begin
`ifdef ACCUMULATOR_16B_SATURATE_EN
                acc_q   <= (add_res[ACC_DATA_WIDTH] || carry_q) ? '1 : add_res[DATA_WIDTH-1:0];
`else
                acc_q   <= add_res[DATA_WIDTH-1:0];
`endif
                carry_q <= carry_q | add_res[ACC_DATA_WIDTH];
            end
        end
    end

    assign sum_o   = acc_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_accumulator_16b.sv
// Self-checking bench for accumulator_16b: directed packets with literal
// expectations, then randomized traffic compared cycle by cycle to a packet-level model.
module tb_accumulator_16b;

    localparam int MAX_TERMS = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] operand_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic [15:0] sum_o;
    logic        carry_o;
    logic [4:0]  count_o;
    logic        valid_o;
    logic        ready_i;

    int n_cmp  = 0;
    int n_fail = 0;

    accumulator_16b dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .operand_i (operand_i),
        .valid_i   (valid_i),
        .last_i    (last_i),
        .ready_o   (ready_o),
        .sum_o     (sum_o),
        .carry_o   (carry_o),
        .count_o   (count_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: the true integer total of the accepted operands.
    bit m_done  = 1'b0;
    int m_total = 0;
    int m_count = 0;
    bit chk_en  = 1'b0;

    function automatic logic [15:0] model_sum(input int total);
`ifdef ACCUMULATOR_16B_SATURATE_EN
        return (total > 65535) ? 16'hFFFF : 16'(total);
`else
        return 16'(total % 65536);
`endif
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_done  <= 1'b0;
            m_total <= 0;
            m_count <= 0;
        end else if (m_done) begin
            if (ready_i) begin
                m_done  <= 1'b0;
                m_total <= 0;
                m_count <= 0;
            end
        end else if (valid_i) begin
            m_total <= m_total + int'(operand_i);
            m_count <= m_count + 1;
            if (last_i || m_count + 1 == MAX_TERMS) m_done <= 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("model ready_o", 32'(ready_o), 32'(!m_done));
            check("model valid_o", 32'(valid_o), 32'(m_done));
            if (m_done) begin
                check("model sum_o",   32'(sum_o),   32'(model_sum(m_total)));
                check("model carry_o", 32'(carry_o), 32'(m_total > 65535));
                check("model count_o", 32'(count_o), 32'(m_count));
            end
        end
    end

    // Entered and left at posedge+1; returns after the accepting edge.
    task automatic send(input logic [15:0] op, input logic last);
        int w = 0;
        operand_i = op;
        last_i    = last;
        valid_i   = 1'b1;
        @(negedge clk_i);
        while (!ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        if (w >= 50) check("send timeout", 32'(w), 32'd0);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [15:0] s, input logic c, input logic [4:0] n);
        int w = 0;
        @(negedge clk_i);
        while (!valid_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        check({name, " latency"}, 32'(w), 32'd0);
        check({name, " sum"},     32'(sum_o),   32'(s));
        check({name, " carry"},   32'(carry_o), 32'(c));
        check({name, " count"},   32'(count_o), 32'(n));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        last_i    = 1'b0;
        operand_i = '0;
        ready_i   = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk_i);
        check("reset ready_o", 32'(ready_o), 32'd1);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset sum_o",   32'(sum_o),   32'd0);
        check("reset carry_o", 32'(carry_o), 32'd0);
        check("reset count_o", 32'(count_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Three-term packet, then ready_o returns the following cycle.
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
        expect_result("three_term", 16'h0006, 1'b0, 5'd3);
        @(negedge clk_i);
        check("three_term ready_after", 32'(ready_o), 32'd1);
        check("three_term valid_after", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Overflow.
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
`ifdef ACCUMULATOR_16B_SATURATE_EN
        expect_result("overflow", 16'hFFFF, 1'b1, 5'd2);
`else
        expect_result("overflow", 16'h0001, 1'b1, 5'd2);
`endif

        // Force-close after MAX_TERMS, then backpressure with valid_i held high.
        ready_i = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) send(16'h0010, 1'b0);
        operand_i = 16'h0020;
        last_i    = 1'b1;
        valid_i   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("hold valid_o", 32'(valid_o), 32'd1);
            check("hold ready_o", 32'(ready_o), 32'd0);
            check("hold sum_o",   32'(sum_o),   32'h0100);
            check("hold count_o", 32'(count_o), 32'd16);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("post_handshake valid_o", 32'(valid_o), 32'd0);
        check("post_handshake ready_o", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        expect_result("held_operand", 16'h0020, 1'b0, 5'd1);

        // Single-term packet.
        send(16'h1234, 1'b1);
        expect_result("single", 16'h1234, 1'b0, 5'd1);

        // Reset mid-packet, with a competing transfer in the reset cycle.
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        rst_i     = 1'b1;
        valid_i   = 1'b1;
        operand_i = 16'h0003;
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("midreset ready_o", 32'(ready_o), 32'd1);
        check("midreset valid_o", 32'(valid_o), 32'd0);
        check("midreset sum_o",   32'(sum_o),   32'd0);
        check("midreset carry_o", 32'(carry_o), 32'd0);
        check("midreset count_o", 32'(count_o), 32'd0);
        @(posedge clk_i);
        #1;
        send(16'h0005, 1'b1);
        expect_result("after_reset", 16'h0005, 1'b0, 5'd1);

        // Randomized traffic, checked every cycle by the model process.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst_i     = ($urandom_range(0, 299) == 0);
            valid_i   = ($urandom_range(0, 3) != 0);
            operand_i = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            last_i    = ($urandom_range(0, 5) == 0);
            ready_i   = ($urandom_range(0, 2) != 0);
            @(posedge clk_i);
            #1;
        end
        rst_i   = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
